// File: rtl/nregister_pipe.sv
// nregister_pipe: DEPTH-stage elastic register chain with valid/ready, bubble collapsing, flush and occupancy count.
// Define NREGISTER_PIPE_PARITY_EN to add per-stage even parity and the io_out_perr output.
module nregister_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           io_in_valid,
    output logic                           io_in_ready,
    input  logic [WIDTH-1:0]               io_in_bits,
    output logic                           io_out_valid,
    input  logic                           io_out_ready,
    output logic [WIDTH-1:0]               io_out_bits,
    input  logic                           io_flush,
`ifdef NREGISTER_PIPE_PARITY_EN
    output logic                           io_out_perr,
`endif
    output logic [$clog2(DEPTH+1)-1:0]     io_count
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0]            v_q, v_d, adv;
    logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        in_hs, out_hs;
`ifdef NREGISTER_PIPE_PARITY_EN
    logic [DEPTH-1:0]            p_q, p_d;
`endif
    // a stage may move when it is empty, the next one is empty, or the next one is itself moving
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = io_out_ready | ~v_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--)
            adv[i] = ~v_q[i] | ~v_q[i+1] | adv[i+1];
        io_in_ready = adv[0] & ~io_flush;
        in_hs = io_in_valid & io_in_ready;
        out_hs = v_q[DEPTH-1] & io_out_ready;
        v_d = v_q;
        d_d = d_q;
        v_d[0] = io_flush ? 1'b0 : adv[0] ? io_in_valid : v_q[0];
        d_d[0] = in_hs ? io_in_bits : d_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            v_d[i] = io_flush ? 1'b0 : adv[i] ? v_q[i-1] : v_q[i];
            d_d[i] = (~io_flush & adv[i] & v_q[i-1]) ? d_q[i-1] : d_q[i];
        end
        cnt_d = io_flush ? '0 : cnt_q + CW'(in_hs) - CW'(out_hs);
    end
`ifdef NREGISTER_PIPE_PARITY_EN
    always_comb begin
        p_d = p_q;
        p_d[0] = in_hs ? ^io_in_bits : p_q[0];
        for (int i = 1; i < DEPTH; i++)
            p_d[i] = (~io_flush & adv[i] & v_q[i-1]) ? p_q[i-1] : p_q[i];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            p_q <= {DEPTH{^RESET_VAL}};
        else
            p_q <= p_d;
    end
    assign io_out_perr = v_q[DEPTH-1] & (p_q[DEPTH-1] ^ (^d_q[DEPTH-1]));
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q   <= '0;
            d_q   <= {DEPTH{RESET_VAL}};
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            cnt_q <= cnt_d;
        end
    end
    assign io_out_valid = v_q[DEPTH-1];
    assign io_out_bits  = d_q[DEPTH-1];
    assign io_count     = cnt_q;
endmodule

// File: tb/tb_nregister_pipe.sv
// tb_nregister_pipe: scoreboard bench for nregister_pipe; parity checks compile in with NREGISTER_PIPE_PARITY_EN.
module tb_nregister_pipe;
    localparam int W = 8;
    localparam int D = 4;
    localparam logic [W-1:0] RV = 8'h3C;
    logic         clk = 1'b0, reset = 1'b0;
    logic         io_in_valid = 1'b0, io_out_ready = 1'b0, io_flush = 1'b0;
    logic         io_in_ready, io_out_valid;
    logic [W-1:0] io_in_bits = '0, io_out_bits;
    logic [2:0]   io_count;
`ifdef NREGISTER_PIPE_PARITY_EN
    logic         io_out_perr;
`endif
    int           n_chk = 0, n_pass = 0, ov_exp = -1, n_acc = 0, peak = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] t1 [3] = '{8'h11, 8'h22, 8'h33};

    always #5 clk = ~clk;

    nregister_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
        .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
        .io_flush(io_flush),
`ifdef NREGISTER_PIPE_PARITY_EN
        .io_out_perr(io_out_perr),
`endif
        .io_count(io_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // one clock: compare at the falling edge, update the scoreboard, then return just after the rising edge
    task automatic cyc();
        logic [W-1:0] e;
        @(negedge clk);
        check("in_ready", io_in_ready, !io_flush && (sb.size() < D || io_out_ready));
        check("count", io_count, sb.size());
        if (ov_exp >= 0) check("out_valid", io_out_valid, ov_exp);
        ov_exp = -1;
`ifdef NREGISTER_PIPE_PARITY_EN
        check("perr", io_out_perr, 0);
`endif
        if (io_out_valid && io_out_ready) begin
            if (sb.size() == 0) check("spurious_out", sb.size(), 1);
            else begin
                e = sb.pop_front();
                check("out_bits", io_out_bits, e);
            end
        end
        if (io_flush) sb.delete();
        if (io_in_valid && io_in_ready) begin
            sb.push_back(io_in_bits);
            n_acc++;
        end
        if (sb.size() > peak) peak = sb.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_out_valid", io_out_valid, 0);
        check("rst_count", io_count, 0);
        check("rst_out_bits", io_out_bits, RV);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("rst_in_ready", io_in_ready, 1);

        io_out_ready = 1'b1;
        peak = 0;
        for (int k = 0; k < 3; k++) begin
            io_in_valid = 1'b1;
            io_in_bits = t1[k];
            ov_exp = 0;
            cyc();
        end
        io_in_valid = 1'b0;
        ov_exp = 0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            ov_exp = 1;
            cyc();
        end
        ov_exp = 0;
        cyc();
        check("t1_peak", peak, 3);

        io_out_ready = 1'b0;
        n_acc = 0;
        io_in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            io_in_bits = 8'hA0 + n_acc[7:0];
            cyc();
        end
        check("t2_accepted", n_acc, 4);
        check("t2_count_full", io_count, 4);
        io_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            io_in_bits = 8'hA0 + n_acc[7:0];
            ov_exp = 1;
            cyc();
        end
        io_in_valid = 1'b0;
        repeat (6) cyc();
        check("t2_drained", io_out_valid, 0);

        io_in_valid = 1'b1;
        io_in_bits = 8'h01;
        cyc();
        io_in_valid = 1'b0;
        cyc();
        io_in_valid = 1'b1;
        io_in_bits = 8'h02;
        cyc();
        io_in_valid = 1'b0;
        io_out_ready = 1'b0;
        repeat (3) cyc();
        check("t3_count", io_count, 2);
        check("t3_head_valid", io_out_valid, 1);
        check("t3_head_bits", io_out_bits, 8'h01);
        io_out_ready = 1'b1;
        ov_exp = 1;
        cyc();
        ov_exp = 1;
        cyc();
        ov_exp = 0;
        cyc();

        io_out_ready = 1'b0;
        io_in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            io_in_bits = 8'h31 + k[7:0];
            cyc();
        end
        check("t4_count_pre", io_count, 3);
        io_flush = 1'b1;
        io_in_bits = 8'h55;
        cyc();
        io_flush = 1'b0;
        io_in_valid = 1'b0;
        ov_exp = 0;
        cyc();
        check("t4_count_post", io_count, 0);
        io_out_ready = 1'b1;
        io_in_valid = 1'b1;
        io_in_bits = 8'h66;
        ov_exp = 0;
        cyc();
        io_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ov_exp = 0;
            cyc();
        end
        ov_exp = 1;
        check("t4_bits_66", io_out_bits, 8'h66);
        cyc();
        cyc();

        io_out_ready = 1'b0;
        io_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            io_in_bits = 8'hC0 + k[7:0];
            cyc();
        end
        io_in_valid = 1'b0;
        check("t5_full", io_count, 4);
        #3 reset = 1'b0;
        #1;
        check("t5_async_valid", io_out_valid, 0);
        check("t5_async_count", io_count, 0);
        check("t5_async_bits", io_out_bits, RV);
        sb.delete();
        @(posedge clk);
        #1 check("t5_held_valid", io_out_valid, 0);
        #2 reset = 1'b1;
        cyc();

        for (int k = 0; k < 300; k++) begin
            io_in_valid = 1'($urandom_range(0, 1));
            io_in_bits = 8'($urandom);
            io_out_ready = ($urandom_range(0, 3) != 0);
            io_flush = ($urandom_range(0, 19) == 0);
            cyc();
        end
        io_flush = 1'b0;
        io_in_valid = 1'b0;
        io_out_ready = 1'b1;
        repeat (6) cyc();
        check("t7_drained", io_out_valid, 0);

`ifdef NREGISTER_PIPE_PARITY_EN
        for (int k = 0; k < 256; k++) begin
            io_in_valid = 1'b1;
            io_in_bits = k[7:0];
            cyc();
        end
        io_in_valid = 1'b0;
        repeat (6) cyc();
        io_out_ready = 1'b0;
        io_in_valid = 1'b1;
        io_in_bits = 8'h5A;
        cyc();
        io_in_valid = 1'b0;
        for (int k = 0; k < 10 && !io_out_valid; k++) cyc();
        check("t6_reach_out", io_out_valid, 1);
        force dut.d_q[D-1][0] = 1'b1;
        #1 check("t6_perr_forced", io_out_perr, 1);
        release dut.d_q[D-1][0];
        io_flush = 1'b1;
        @(posedge clk);
        #1 io_flush = 1'b0;
        sb.delete();
        check("t6_perr_clear", io_out_perr, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
